// File: rtl/blowfish_pkg.sv
// Shared definitions for the Blowfish P-array key-mixing block.
// Purpose: holds the pi-fraction initial P-array values, the
//          controller state encoding and the maximum P-array depth.
// Ports:   none (package).
package blowfish_pkg;

  localparam int NP_MAX = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Leading 32-bit words of the hexadecimal fraction of pi.
  localparam logic [31:0] PI_INIT [0:NP_MAX-1] = '{
    32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344,
    32'hA4093822, 32'h299F31D0, 32'h082EFA98, 32'hEC4E6C89,
    32'h452821E6, 32'h38D01377, 32'hBE5466CF, 32'h34E90C6C,
    32'hC0AC29B7, 32'hC97C50DD, 32'h3F84D5B5, 32'hB5470917,
    32'h9216D5D9, 32'h8979FB1B, 32'hD1310BA6, 32'h98DFB5AC
  };

endpackage

// File: rtl/blowfish_key_store.sv
// Key word register file for the P-array key-mixing block.
// Purpose: WORDS x 32-bit storage with one synchronous write port
//          and one asynchronous read port.
// Ports:   clk/rst  - clock and synchronous active-high reset
//          wr_en    - write strobe (already gated by the caller)
//          wr_idx   - write word index; indices >= WORDS are dropped
//          wr_data  - write data
//          rd_idx   - async read index
//          rd_data  - async read data
module blowfish_key_store
  import blowfish_pkg::*;
#(
  parameter int WORDS = 16,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_data
);

  // One bit per addressable index: set where the index names a real word.
  localparam logic [2**AW-1:0] WORD_OK = {(2**AW){1'b1}} >> (2**AW - WORDS);

  logic [31:0] mem_q [0:WORDS-1];
  logic [31:0] mem_d [0:WORDS-1];

  always_comb begin
    mem_d = mem_q;
    if (wr_en && WORD_OK[wr_idx]) begin
      mem_d[wr_idx] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/blowfish_parray_keymix.sv
// Blowfish key-schedule key-mixing phase.
// Purpose: loads each P-array entry with its pi constant XORed with key
//          words taken cyclically over a programmable key length, one
//          entry per clock, and serves the P-array through an indexed,
//          registered read port with forward or reversed ordering.
// Ports:   Clk/Rst    - clock, synchronous active-high reset
//          key_wr/key_widx/key_wdata - key word write port (ignored in MIX)
//          key_len    - key length in words, taken when a start is accepted
//          Enable     - start request, acts on its rising edge
//          Encrypt    - 1 forward readout, 0 reversed readout
//          rd_idx     - P entry read index; rd_data one cycle later
//          skey_ready - P-array complete, busy - mixing, err - rejected start
module blowfish_parray_keymix
  import blowfish_pkg::*;
#(
  parameter int ROUNDS        = 18,
  parameter int KEY_WORDS_MAX = 16,
  parameter int KLW           = $clog2(KEY_WORDS_MAX + 1),
  parameter int PIW           = $clog2(ROUNDS + 2)
) (
  input  logic                             Clk,
  input  logic                             Rst,
  input  logic                             key_wr,
  input  logic [$clog2(KEY_WORDS_MAX)-1:0] key_widx,
  input  logic [31:0]                      key_wdata,
  input  logic [KLW-1:0]                   key_len,
  input  logic                             Enable,
  input  logic                             Encrypt,
  input  logic [PIW-1:0]                   rd_idx,
  output logic [31:0]                      rd_data,
  output logic                             skey_ready,
  output logic                             busy,
  output logic                             err
);

  localparam int NP  = ROUNDS + 2;
  localparam int KIW = $clog2(KEY_WORDS_MAX);

  localparam logic [2**PIW-1:0] IDX_OK = {(2**PIW){1'b1}} >> (2**PIW - NP);

  state_e         state_q, state_d;
  logic [PIW-1:0] p_i_q, p_i_d;
  logic [KIW-1:0] k_i_q, k_i_d;
  logic [KLW-1:0] klen_q, klen_d;
  logic           err_q, err_d;
  logic           enable_s1_q, enable_s1_d;
  logic           enable_s2_q, enable_s2_d;
  logic [31:0]    rd_data_q, rd_data_d;
  logic [31:0]    p_q [0:NP-1];
  logic [31:0]    p_d [0:NP-1];

  logic [31:0]    key_rdata;
  logic           start;
  logic           len_ok;
  logic [PIW-1:0] rd_sel;

  blowfish_key_store #(
    .WORDS (KEY_WORDS_MAX),
    .AW    (KIW)
  ) u_key_store (
    .clk     (Clk),
    .rst     (Rst),
    .wr_en   (key_wr && (state_q != MIX)),
    .wr_idx  (key_widx),
    .wr_data (key_wdata),
    .rd_idx  (k_i_q),
    .rd_data (key_rdata)
  );

  // Enable is registered first and the start is its registered rising
  // edge, so a level held high cannot retrigger after DONE.
  assign enable_s1_d = Enable;
  assign enable_s2_d = enable_s1_q;
  assign start       = enable_s1_q & ~enable_s2_q;
  assign len_ok      = (key_len != '0) && (key_len <= KLW'(KEY_WORDS_MAX));

  always_comb begin
    state_d = state_q;
    p_i_d   = p_i_q;
    k_i_d   = k_i_q;
    klen_d  = klen_q;
    err_d   = 1'b0;
    p_d     = p_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (len_ok) begin
            state_d = MIX;
            klen_d  = key_len;
            p_i_d   = '0;
            k_i_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      MIX: begin
        p_d[p_i_q] = PI_INIT[p_i_q] ^ key_rdata;
        if (KLW'(k_i_q) == klen_q - KLW'(1)) begin
          k_i_d = '0;
        end else begin
          k_i_d = k_i_q + KIW'(1);
        end
        if (p_i_q == PIW'(NP - 1)) begin
          state_d = DONE;
          p_i_d   = '0;
        end else begin
          p_i_d = p_i_q + PIW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Decrypt order reads the array back to front; out-of-range reads give 0.
  always_comb begin
    rd_sel    = Encrypt ? rd_idx : (PIW'(NP - 1) - rd_idx);
    rd_data_d = '0;
    if (IDX_OK[rd_idx]) begin
      rd_data_d = p_q[rd_sel];
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      p_i_q       <= '0;
      k_i_q       <= '0;
      klen_q      <= '0;
      err_q       <= 1'b0;
      enable_s1_q <= 1'b0;
      enable_s2_q <= 1'b0;
      rd_data_q   <= '0;
      p_q         <= '{default: '0};
    end else begin
      state_q     <= state_d;
      p_i_q       <= p_i_d;
      k_i_q       <= k_i_d;
      klen_q      <= klen_d;
      err_q       <= err_d;
      enable_s1_q <= enable_s1_d;
      enable_s2_q <= enable_s2_d;
      rd_data_q   <= rd_data_d;
      p_q         <= p_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign skey_ready = (state_q == DONE);
  assign busy       = (state_q == MIX);
  assign err        = err_q;

endmodule

// File: tb/tb_blowfish_parray_keymix.sv
// Directed self-checking bench for blowfish_parray_keymix (default
// parameters: 18 rounds, 20 P entries, up to 16 key words).
module tb_blowfish_parray_keymix;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        key_wr;
   logic [3:0]  key_widx;
   logic [31:0] key_wdata;
   logic [4:0]  key_len;
   logic        Enable;
   logic        Encrypt;
   logic [4:0]  rd_idx;
   logic [31:0] rd_data;
   logic        skey_ready;
   logic        busy;
   logic        err;

   int total = 0;
   int bad   = 0;

   logic [31:0] piTab [20] = '{
      32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344,
      32'hA4093822, 32'h299F31D0, 32'h082EFA98, 32'hEC4E6C89,
      32'h452821E6, 32'h38D01377, 32'hBE5466CF, 32'h34E90C6C,
      32'hC0AC29B7, 32'hC97C50DD, 32'h3F84D5B5, 32'hB5470917,
      32'h9216D5D9, 32'h8979FB1B, 32'hD1310BA6, 32'h98DFB5AC
   };

   blowfish_parray_keymix dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .key_wr     (key_wr),
      .key_widx   (key_widx),
      .key_wdata  (key_wdata),
      .key_len    (key_len),
      .Enable     (Enable),
      .Encrypt    (Encrypt),
      .rd_idx     (rd_idx),
      .rd_data    (rd_data),
      .skey_ready (skey_ready),
      .busy       (busy),
      .err        (err)
   );

   // Free-running 100 MHz clock
   always #5 Clk = ~Clk;

   // Hard stop in case something in the bench itself wedges
   initial begin
      #200000;
      $display("[TB] FAIL watchdog simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Advance one clock and settle just past the rising edge
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Single comparison point: counts every check, reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // One key-word write cycle
   task automatic writeKey(input logic [3:0] idx, input logic [31:0] data);
      key_wr    = 1'b1;
      key_widx  = idx;
      key_wdata = data;
      tick();
      key_wr    = 1'b0;
   endtask

   // Present a start request for one cycle with the given key length
   task automatic applyStimulus(input logic [4:0] len);
      key_len = len;
      Enable  = 1'b1;
      tick();
      Enable  = 1'b0;
   endtask

   // Count cycles until skey_ready, bounded
   task automatic waitReady(output int cycles);
      cycles = 0;
      do begin
         tick();
         cycles++;
      end while (!skey_ready && cycles < 60);
   endtask

   // Registered readout: drive index, return data one cycle later
   task automatic readP(input logic [4:0] idx, input logic enc, output logic [31:0] data);
      rd_idx  = idx;
      Encrypt = enc;
      tick();
      data = rd_data;
   endtask

   // Compare the whole P-array against pi ^ cyclic two-word key model
   task automatic checkAll(input string tag, input logic [31:0] k0, input logic [31:0] k1, input int klen);
      logic [31:0] got;
      logic [31:0] exp;
      for (int i = 0; i < 20; i++) begin
         exp = piTab[i] ^ ((klen == 1 || (i % 2) == 0) ? k0 : k1);
         readP(5'(i), 1'b1, got);
         checkOutput($sformatf("%s_P%0d", tag, i), got, exp);
      end
   endtask

   // Zero check of the whole P-array
   task automatic checkZero(input string tag);
      logic [31:0] got;
      for (int i = 0; i < 20; i++) begin
         readP(5'(i), 1'b1, got);
         checkOutput($sformatf("%s_P%0d", tag, i), got, 32'h0);
      end
   endtask

   // Main directed sequence
   initial begin
      int          cycles;
      logic [31:0] got;

      Rst = 1'b1; key_wr = 1'b0; key_widx = '0; key_wdata = '0;
      key_len = '0; Enable = 1'b0; Encrypt = 1'b1; rd_idx = '0;
      tick();
      tick();
      Rst = 1'b0;

      $display("[TB] reset state");
      checkOutput("rst_busy", 32'(busy), 32'h0);
      checkOutput("rst_ready", 32'(skey_ready), 32'h0);
      checkOutput("rst_err", 32'(err), 32'h0);
      checkOutput("rst_rd_data", rd_data, 32'h0);
      readP(5'd0, 1'b1, got);
      checkOutput("rst_P0", got, 32'h0);

      $display("[TB] rejected starts in IDLE");
      applyStimulus(5'd0);
      tick();
      checkOutput("len0_err", 32'(err), 32'h1);
      tick();
      checkOutput("len0_err_clear", 32'(err), 32'h0);
      checkOutput("len0_busy", 32'(busy), 32'h0);
      checkOutput("len0_ready", 32'(skey_ready), 32'h0);
      applyStimulus(5'd17);
      tick();
      checkOutput("len17_err", 32'(err), 32'h1);
      tick();
      checkOutput("len17_err_clear", 32'(err), 32'h0);
      checkOutput("len17_busy", 32'(busy), 32'h0);
      checkOutput("len17_ready", 32'(skey_ready), 32'h0);

      $display("[TB] zero key, length 1");
      writeKey(4'd0, 32'h0);
      applyStimulus(5'd1);
      waitReady(cycles);
      checkOutput("t1_latency", 32'(cycles), 32'd21);
      checkOutput("t1_busy_done", 32'(busy), 32'h0);
      checkAll("t1", 32'h0, 32'h0, 1);

      $display("[TB] alternating two-word key");
      writeKey(4'd0, 32'hFFFFFFFF);
      writeKey(4'd1, 32'h00000000);
      applyStimulus(5'd2);
      tick();
      checkOutput("t2_ready_drop", 32'(skey_ready), 32'h0);
      checkOutput("t2_busy", 32'(busy), 32'h1);
      waitReady(cycles);
      checkOutput("t2_latency", 32'(cycles + 1), 32'd21);
      readP(5'd0, 1'b1, got); checkOutput("t2_P0", got, 32'hDBC09577);
      readP(5'd1, 1'b1, got); checkOutput("t2_P1", got, 32'h85A308D3);
      readP(5'd2, 1'b1, got); checkOutput("t2_P2", got, 32'hECE675D1);
      readP(5'd3, 1'b1, got); checkOutput("t2_P3", got, 32'h03707344);
      checkAll("t2", 32'hFFFFFFFF, 32'h0, 2);

      $display("[TB] reversed readout");
      readP(5'd0, 1'b0, got);  checkOutput("dec_idx0", got, 32'h98DFB5AC);
      readP(5'd19, 1'b0, got); checkOutput("dec_idx19", got, 32'hDBC09577);
      readP(5'd20, 1'b0, got); checkOutput("dec_idx20", got, 32'h0);
      readP(5'd20, 1'b1, got); checkOutput("enc_idx20", got, 32'h0);

      $display("[TB] rejected start in DONE keeps P");
      applyStimulus(5'd0);
      tick();
      checkOutput("done_err", 32'(err), 32'h1);
      checkOutput("done_ready_kept", 32'(skey_ready), 32'h1);
      readP(5'd0, 1'b1, got);
      checkOutput("done_P0_kept", got, 32'hDBC09577);
      checkOutput("done_err_clear", 32'(err), 32'h0);

      $display("[TB] key write during MIX is ignored");
      applyStimulus(5'd2);
      tick();
      tick();
      tick();
      checkOutput("t5_busy", 32'(busy), 32'h1);
      writeKey(4'd0, 32'h12345678);
      waitReady(cycles);
      checkOutput("t5_ready", 32'(skey_ready), 32'h1);
      checkAll("t5", 32'hFFFFFFFF, 32'h0, 2);

      $display("[TB] reset mid-MIX");
      applyStimulus(5'd2);
      for (int i = 0; i < 11; i++) tick();
      checkOutput("t6_busy_pre", 32'(busy), 32'h1);
      Rst = 1'b1;
      tick();
      checkOutput("t6_busy", 32'(busy), 32'h0);
      checkOutput("t6_ready", 32'(skey_ready), 32'h0);
      Rst = 1'b0;
      checkZero("t6_zero");
      applyStimulus(5'd1);
      waitReady(cycles);
      checkOutput("t6_latency", 32'(cycles), 32'd21);
      checkAll("t6", 32'h0, 32'h0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
